// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered magnitude comparator between two requesters.
// Define CMP_SIGNED_EN to compare operands as two's complement (unsigned ordering otherwise).
module cmp_arbiter #(
  parameter int WIDTH      = 4,
  parameter int CMP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             ack1,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_eq,
  output logic             rsp_gt,
  output logic             rsp_lt,
  output logic [WIDTH-1:0] rsp_max
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CMP_CYCLES - 1);

  state_t           state;
  logic             last_id;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             grant1;
  logic             cmp_eq;
  logic             cmp_gt;

  // On a tie the requester that was not served last wins.
  assign grant1 = req1 & (~req0 | ~last_id);

  assign cmp_eq = (x_q == y_q);
`ifdef CMP_SIGNED_EN
  assign cmp_gt = ($signed(x_q) > $signed(y_q));
`else
  assign cmp_gt = (x_q > y_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      cnt       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_max   <= '0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= BUSY;
            busy    <= 1'b1;
            cnt     <= CNT_LOAD;
            last_id <= grant1;
            x_q     <= grant1 ? x1 : x0;
            y_q     <= grant1 ? y1 : y0;
            ack0    <= ~grant1;
            ack1    <= grant1;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            // Response fields stay latched until the next operation completes.
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= last_id;
            rsp_eq    <= cmp_eq;
            rsp_gt    <= cmp_gt;
            rsp_lt    <= ~cmp_eq & ~cmp_gt;
            rsp_max   <= cmp_gt ? x_q : y_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
